// File: rtl/ws2812_driver.sv
// ws2812_driver
//   Serialises a 16-pixel frame buffer onto a single WS2812 data line, then
//   holds the line low long enough for the strip to latch the new colours.
//
//   Build option: define WS2812_DIM_EN to shift every 8-bit sub-pixel right
//   by 2 when the frame is captured (1/4 brightness). Timing, ports and FSM
//   are identical with or without it.
//
// Parameters
//   T0H     high cycles for a 0 bit
//   T1H     high cycles for a 1 bit
//   TBIT    total cycles per bit (T0H < T1H < TBIT)
//   TRESET  low cycles after the last bit
//
// Ports
//   clk        single clock, rising edge
//   nrst       asynchronous active-low reset
//   framebuf   16 x 24-bit pixels, pixel p at [24p+23:24p], bytes G,R,B from LSB
//   start      one-cycle request, honoured only while idle
//   dout       serial data to the strip
//   busy       high from the cycle after start is accepted through the done cycle
//   done       one-cycle pulse on the final latch cycle
//   fsm_state  current FSM state (0 IDLE, 1 SEND, 2 LATCH) for observation
//
// Handshake: start is a single-cycle request sampled on a rising edge. It is
// accepted only when busy is low; requests seen while busy (including the
// done cycle) are dropped, never queued.
module ws2812_driver #(
    parameter int T0H    = 4,
    parameter int T1H    = 9,
    parameter int TBIT   = 15,
    parameter int TRESET = 600
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [383:0] framebuf,
    input  logic         start,
    output logic         dout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   fsm_state
);

    localparam int NBITS = 384;
    localparam int PH_W  = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int LT_W  = (TRESET > 1) ? $clog2(TRESET) : 1;

    localparam logic [PH_W-1:0] PH_T0H  = PH_W'(T0H);
    localparam logic [PH_W-1:0] PH_T1H  = PH_W'(T1H);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TBIT - 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(TRESET - 1);
    localparam logic [8:0]      BIT_LAST = 9'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic [8:0]        bit_q, bit_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [LT_W-1:0]   latch_q, latch_d;

    // Reorder the frame so the first bit on the wire sits at the top of the
    // shift register. Byte slot s (pixel s/3, colour s%3) is already MSB-first
    // inside a byte, so only the byte order needs reversing.
    function automatic logic [NBITS-1:0] load_frame(input logic [NBITS-1:0] fb);
        logic [NBITS-1:0] r;
        logic [7:0]       sub;
        r = '0;
        for (int s = 0; s < NBITS / 8; s++) begin
            sub = fb[8*s +: 8];
`ifdef WS2812_DIM_EN
            sub = {2'b00, sub[7:2]};
`endif
            r[NBITS-1-8*s -: 8] = sub;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        latch_d = latch_q;
        dout    = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = load_frame(framebuf);
                    bit_d   = '0;
                    phase_d = '0;
                    latch_d = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                // The high part of each bit always starts at phase 0, so
                // bits run back-to-back with no gap.
                dout = shreg_q[NBITS-1] ? (phase_q < PH_T1H) : (phase_q < PH_T0H);
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    shreg_d = {shreg_q[NBITS-2:0], 1'b0};
                    if (bit_q == BIT_LAST) begin
                        latch_d = '0;
                        state_d = LATCH;
                    end else begin
                        bit_d = bit_q + 9'd1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            LATCH: begin
                if (latch_q == LT_LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    latch_d = latch_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver
//   Directed bench for ws2812_driver: table of frame buffers with hand-derived
//   transmitted bit streams, plus sequences for ignored start, mid-frame
//   reset and back-to-back frames with start held high.
//   exp_bits[i] is the i-th bit on the wire (bit 0 sent first).
module tb_ws2812_driver;

    localparam int T0H    = 4;
    localparam int T1H    = 9;
    localparam int TBIT   = 15;
    localparam int TRESET = 600;
    localparam int NBITS  = 384;
    localparam int SEND_C = NBITS * TBIT;          // 5760
    localparam int FRAME  = SEND_C + TRESET;       // 6360
    localparam int MAXC   = 7000;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic [383:0] framebuf;
    logic         dout;
    logic         busy;
    logic         done;
    logic [1:0]   fsm_state;

    ws2812_driver #(
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .clk(clk), .nrst(nrst), .framebuf(framebuf), .start(start),
        .dout(dout), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic dout_log [0:MAXC+1];
    logic busy_log [0:MAXC+1];
    logic done_log [0:MAXC+1];
    int   done_cycle;

    typedef struct {
        logic [383:0] fb;
        logic [383:0] exp_bits;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Pulses start, then logs outputs on every falling edge; cycle k is the
    // k-th cycle after the accepting edge. Optionally injects a second start
    // and a framebuf change at cycle inj_cycle.
    task automatic capture(input int inj_cycle, input logic [383:0] inj_fb);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cycle = 0;
        for (int k = 1; k <= MAXC; k++) begin
            @(negedge clk);
            dout_log[k] = dout;
            busy_log[k] = busy;
            done_log[k] = done;
            if (k == inj_cycle) begin
                start    = 1'b1;
                framebuf = inj_fb;
            end else if (k == inj_cycle + 1) begin
                start = 1'b0;
            end
            if (done && done_cycle == 0) done_cycle = k;
            if (done_cycle != 0 && k == done_cycle + 1) break;
        end
    endtask

    // ---------------- checker ----------------
    task automatic check_frame(input string name, input logic [383:0] exp_bits);
        int bad_bits;
        int latch_high;
        int done_cnt;
        int busy_low;
        int hi;
        bad_bits   = 0;
        latch_high = 0;
        done_cnt   = 0;
        busy_low   = 0;
        check({name, "_done_cycle"}, done_cycle, FRAME);
        for (int i = 0; i < NBITS; i++) begin
            logic bad;
            bad = 1'b0;
            hi  = exp_bits[i] ? T1H : T0H;
            for (int j = 0; j < TBIT; j++) begin
                if (dout_log[1 + i*TBIT + j] !== (j < hi)) bad = 1'b1;
            end
            if (bad) bad_bits++;
        end
        check({name, "_bad_bits"}, bad_bits, 0);
        for (int c = SEND_C + 1; c <= FRAME; c++) begin
            if (dout_log[c] !== 1'b0) latch_high++;
        end
        check({name, "_latch_high"}, latch_high, 0);
        for (int c = 1; c <= FRAME + 1; c++) begin
            if (done_log[c] === 1'b1) done_cnt++;
            if (c <= FRAME && busy_log[c] !== 1'b1) busy_low++;
        end
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_low"}, busy_low, 0);
        check({name, "_busy_after"}, int'(busy_log[FRAME + 1]), 0);
    endtask

    // ---------------- test ----------------
    initial begin
        // Stimulus table
        vecs[0].fb = '0;                        // all off
        vecs[1].fb = 384'hFF;                   // pixel 0 green = FF
        vecs[2].fb = 384'h80_0000;              // pixel 0 blue = 80
        vecs[3].fb = 384'h1 << 368;             // pixel 15 red = 01
        vecs[4].fb = 384'hA5 << 24;             // pixel 1 green = A5
        vecs[5].fb = '1;                        // all full
`ifdef WS2812_DIM_EN
        vecs[0].exp_bits = '0;
        vecs[1].exp_bits = 384'hFC;             // 3F sent as 0,0,1,1,1,1,1,1
        vecs[2].exp_bits = 384'h4_0000;         // 20 -> wire bit 18
        vecs[3].exp_bits = '0;                  // 01 >> 2 = 0
        vecs[4].exp_bits = 384'h94 << 24;       // 29 -> wire bits 26,28,31
        vecs[5].exp_bits = {48{8'hFC}};         // every byte 3F
`else
        vecs[0].exp_bits = '0;
        vecs[1].exp_bits = 384'hFF;             // wire bits 0..7
        vecs[2].exp_bits = 384'h1_0000;         // MSB of blue -> wire bit 16
        vecs[3].exp_bits = 384'h1 << 375;       // LSB of slot 46 -> wire bit 375
        vecs[4].exp_bits = 384'hA5 << 24;       // wire bits 24,26,29,31
        vecs[5].exp_bits = '1;
`endif

        // Reset state (asynchronous, before any clock edge)
        nrst     = 1'b0;
        start    = 1'b0;
        framebuf = '0;
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(fsm_state), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            framebuf = vecs[v].fb;
            capture(0, '0);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_bits);
        end

        // Second start plus framebuf change 100 cycles into SEND: ignored
        framebuf = vecs[2].fb;
        capture(100, '1);
        check_frame("ignored_start", vecs[2].exp_bits);
        begin
            int busy_hi;
            busy_hi = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy) busy_hi++;
            end
            check("not_queued_busy", busy_hi, 0);
        end

        // Reset mid-SEND abandons the frame
        framebuf = '0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3001) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_dout", int'(dout), 1);
        nrst = 1'b0;
        #1;
        check("mid_reset_dout", int'(dout), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_done", int'(done), 0);
        begin
            int done_seen;
            done_seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (done) done_seen++;
            end
            check("mid_reset_no_done", done_seen, 0);
        end
        nrst = 1'b1;
        // Start on the very first edge after release
        capture(0, '0);
        check_frame("after_reset", '0);

        // start held high: one idle cycle between done and next dout rise
        start = 1'b1;
        begin
            int found;
            found = 0;
            for (int k = 0; k < MAXC; k++) begin
                @(negedge clk);
                if (done) begin
                    found = 1;
                    break;
                end
            end
            check("held_done_seen", found, 1);
            @(negedge clk);
            check("held_gap_dout", int'(dout), 0);
            check("held_gap_busy", int'(busy), 0);
            @(negedge clk);
            check("held_restart_dout", int'(dout), 1);
            check("held_restart_busy", int'(busy), 1);
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
